// File: rtl/io_responder_pkg.sv
// rtl/io_responder_pkg.sv - shared IO region constants, register offsets and decode helper
package io_responder_pkg;

  // Region tag and offsets are shared with memory control so both agree on the map.
  localparam logic [3:0] IO_REGION  = 4'h8;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CNTCLR = 8'h18;

  localparam int STAT_TX_IDLE_BIT     = 0;
  localparam int STAT_RX_NONEMPTY_BIT = 1;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CTRL,
    REG_RXDATA,
    REG_TXDATA,
    REG_CYCLE,
    REG_INSTR,
    REG_CNTCLR
  } io_reg_e;

  function automatic io_reg_e decode_offset(input logic [7:0] off);
    case (off)
      OFF_CTRL:   return REG_CTRL;
      OFF_RXDATA: return REG_RXDATA;
      OFF_TXDATA: return REG_TXDATA;
      OFF_CYCLE:  return REG_CYCLE;
      OFF_INSTR:  return REG_INSTR;
      OFF_CNTCLR: return REG_CNTCLR;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// rtl/io_rx_fifo.sv - power-of-two receive byte FIFO with occupancy counter
module io_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  // Guards here keep the FIFO safe even if a caller ignores full/empty.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_responder.sv
// rtl/io_responder.sv - memory-mapped IO responder: UART tx/rx, cycle and instruction counters
module io_responder
  import io_responder_pkg::*;
#(
  parameter int RX_DEPTH = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_a,
  input  logic [3:0]  i_io_trans,
  input  logic        i_io_recv,
  input  logic [31:0] i_write_data,
  input  logic        i_instr_retire,
  output logic [31:0] o_read_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready
);

  logic [31:0] r_read_data;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  logic        w_sel;
  logic        w_any_strobe;
  logic        w_store;
  logic        w_load;
  io_reg_e     w_reg;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic [7:0]  w_rx_dout;
  logic        w_push;
  logic        w_pop;
  logic        w_tx_load;
  logic        w_cnt_clr;
  logic [31:0] w_status;
  logic [31:0] w_load_data;
  logic        w_unused;

  assign w_unused = ^{i_a[27:8], i_write_data[31:8]};

  // A store strobe in the same cycle as a load strobe makes it a store only.
  assign w_sel        = (i_a[31:28] == IO_REGION);
  assign w_any_strobe = |i_io_trans;
  assign w_store      = w_sel && w_any_strobe;
  assign w_load       = w_sel && i_io_recv && !w_any_strobe;
  assign w_reg        = decode_offset(i_a[7:0]);

  assign w_push    = i_rx_valid && !w_rx_full;
  assign w_pop     = w_load && (w_reg == REG_RXDATA) && !w_rx_empty;
  assign w_tx_load = w_store && (w_reg == REG_TXDATA) && i_io_trans[0] && !r_tx_valid;
  assign w_cnt_clr = w_store && (w_reg == REG_CNTCLR);

  io_rx_fifo #(
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .i_clk   (i_clock),
    .i_rst   (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (i_rx_data),
    .o_dout  (w_rx_dout),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  always_comb begin
    w_status = 32'h0;
    w_status[STAT_TX_IDLE_BIT]     = !r_tx_valid;
    w_status[STAT_RX_NONEMPTY_BIT] = !w_rx_empty;
  end

  always_comb begin
    w_load_data = 32'h0;
    case (w_reg)
      REG_CTRL:   w_load_data = w_status;
      REG_RXDATA: w_load_data = w_rx_empty ? 32'h0 : {24'h0, w_rx_dout};
      REG_CYCLE:  w_load_data = r_cycle_cnt;
      REG_INSTR:  w_load_data = r_instr_cnt;
      default:    w_load_data = 32'h0;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_read_data <= 32'h0;
    end else if (w_load) begin
      r_read_data <= w_load_data;
    end
  end

  // Holding register: a byte stays put until the UART takes it; stores in the meantime are dropped.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else if (w_tx_load) begin
      r_tx_data  <= i_write_data[7:0];
      r_tx_valid <= 1'b1;
    end else if (r_tx_valid && i_tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cycle_cnt <= 32'h0;
      r_instr_cnt <= 32'h0;
    end else if (w_cnt_clr) begin
      r_cycle_cnt <= 32'h0;
      r_instr_cnt <= 32'h0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'h1;
      if (i_instr_retire) begin
        r_instr_cnt <= r_instr_cnt + 32'h1;
      end
    end
  end

  assign o_read_data = r_read_data;
  assign o_tx_data   = r_tx_data;
  assign o_tx_valid  = r_tx_valid;
  assign o_rx_ready  = !w_rx_full;

endmodule
